// File: rtl/cpu_bus_arbiter.sv
// CPU read-data arbiter: priority mux over NCH sources with an open-bus
// latch, open-bus hit pulse and sticky multi-select conflict tracking.
module cpu_bus_arbiter #(
   parameter int         NCH           = 2,
   parameter int         OPEN_BUS      = 1,
   parameter int         DEFAULT_CH    = 0,
   parameter logic [7:0] OPEN_BUS_INIT = 8'hFF
) (
   input  logic             MCLK,
   input  logic             RESET,
   input  logic             SYSCLKF_CE,
   input  logic             CPURD_N,
   input  logic             CPUWR_N,
   input  logic [7:0]       CPU_DO,
   input  logic [NCH-1:0]   CH_SEL,
   input  logic [NCH*8-1:0] CH_DO,
   input  logic [NCH-1:0]   CH_EN,
   input  logic             CONFLICT_CLR,
   output logic [7:0]       DI,
   output logic [3:0]       DI_SRC,
   output logic             OPEN_BUS_HIT,
   output logic             CONFLICT,
   output logic [7:0]       CONFLICT_CNT,
   output logic [NCH-1:0]   CONFLICT_MASK
);

   localparam bit OB = (OPEN_BUS != 0);

   logic [NCH-1:0] eff;
   logic [3:0]     win;
   logic [7:0]     win_do;
   logic [7:0]     ob_q;
   logic           any;
   logic           multi;
   logic           rd_cycle;
   logic           evt;

   assign eff      = CH_SEL & CH_EN;
   assign any      = |eff;
   // clearing the lowest set bit leaves something only if two or more were set
   assign multi    = |(eff & (eff - 1'b1));
   assign rd_cycle = SYSCLKF_CE & ~CPURD_N;
   assign evt      = rd_cycle & multi;

   // scan downward so the lowest set index wins
   always_comb begin
      win    = '0;
      win_do = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (eff[i]) begin
            win    = 4'(i);
            win_do = CH_DO[i*8 +: 8];
         end
      end
   end

   always_comb begin
      DI     = '0;
      DI_SRC = 4'(NCH);
      if (any) begin
         DI     = win_do;
         DI_SRC = win;
      end else if (OB) begin
         DI = ob_q;
      end else begin
         DI = CH_DO[DEFAULT_CH*8 +: 8];
      end
   end

   always_ff @(posedge MCLK) begin
      if (RESET) begin
         ob_q         <= OPEN_BUS_INIT;
         OPEN_BUS_HIT <= 1'b0;
      end else begin
         OPEN_BUS_HIT <= rd_cycle & ~any & OB;
         if (SYSCLKF_CE) begin
            if (!CPUWR_N)      ob_q <= CPU_DO;
            else if (!CPURD_N) ob_q <= DI;
         end
      end
   end

   always_ff @(posedge MCLK) begin
      if (RESET) begin
         CONFLICT      <= 1'b0;
         CONFLICT_CNT  <= '0;
         CONFLICT_MASK <= '0;
      end else if (CONFLICT_CLR) begin
         CONFLICT      <= evt;
         CONFLICT_CNT  <= evt ? 8'd1 : 8'd0;
         CONFLICT_MASK <= evt ? eff : '0;
      end else if (evt) begin
         CONFLICT <= 1'b1;
         if (CONFLICT_CNT != 8'hFF) CONFLICT_CNT <= CONFLICT_CNT + 8'd1;
         if (!CONFLICT) CONFLICT_MASK <= eff;
      end
   end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: a default 2-source instance, a
// default-channel (no open-bus) instance and an 8-source instance.
module tb_cpu_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic        rd_n;
   logic        wr_n;
   logic [7:0]  cpu_do;
   logic [1:0]  sel;
   logic [15:0] ch_do;
   logic [1:0]  en;
   logic        clr;
   logic [7:0]  sel8;
   logic [63:0] ch_do8;
   logic [7:0]  en8;

   logic [7:0]  di_a, cnt_a, di_b, cnt_b, di_8, cnt_8, mask_8;
   logic [3:0]  src_a, src_b, src_8;
   logic        hit_a, conf_a, hit_b, conf_b, hit_8, conf_8;
   logic [1:0]  mask_a, mask_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cpu_bus_arbiter dut_a (
      .MCLK(clk), .RESET(reset), .SYSCLKF_CE(ce), .CPURD_N(rd_n),
      .CPUWR_N(wr_n), .CPU_DO(cpu_do), .CH_SEL(sel), .CH_DO(ch_do),
      .CH_EN(en), .CONFLICT_CLR(clr), .DI(di_a), .DI_SRC(src_a),
      .OPEN_BUS_HIT(hit_a), .CONFLICT(conf_a), .CONFLICT_CNT(cnt_a),
      .CONFLICT_MASK(mask_a)
   );

   cpu_bus_arbiter #(.NCH(2), .OPEN_BUS(0), .DEFAULT_CH(1)) dut_b (
      .MCLK(clk), .RESET(reset), .SYSCLKF_CE(ce), .CPURD_N(rd_n),
      .CPUWR_N(wr_n), .CPU_DO(cpu_do), .CH_SEL(sel), .CH_DO(ch_do),
      .CH_EN(en), .CONFLICT_CLR(clr), .DI(di_b), .DI_SRC(src_b),
      .OPEN_BUS_HIT(hit_b), .CONFLICT(conf_b), .CONFLICT_CNT(cnt_b),
      .CONFLICT_MASK(mask_b)
   );

   cpu_bus_arbiter #(.NCH(8)) dut_8 (
      .MCLK(clk), .RESET(reset), .SYSCLKF_CE(ce), .CPURD_N(rd_n),
      .CPUWR_N(wr_n), .CPU_DO(cpu_do), .CH_SEL(sel8), .CH_DO(ch_do8),
      .CH_EN(en8), .CONFLICT_CLR(clr), .DI(di_8), .DI_SRC(src_8),
      .OPEN_BUS_HIT(hit_8), .CONFLICT(conf_8), .CONFLICT_CNT(cnt_8),
      .CONFLICT_MASK(mask_8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ce   = 1'b0;
      rd_n = 1'b1;
      wr_n = 1'b1;
      clr  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      cpu_do = 8'h00;
      sel    = 2'b00;
      en     = 2'b11;
      ch_do  = {8'hA5, 8'h3C};
      sel8   = 8'h00;
      en8    = 8'hFF;
      ch_do8 = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      tick();
      tick();
      checks++;
      if (di_a !== 8'hFF) begin
         errors++;
         $display("FAIL reset_di got=%h exp=ff", di_a);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (src_a !== 4'd2) begin
         errors++;
         $display("FAIL reset_src got=%0d exp=2", src_a);
      end
      checks++;
      if ({hit_a, conf_a, cnt_a, mask_a} !== 11'd0) begin
         errors++;
         $display("FAIL reset_state got=%b/%b/%h/%b exp=0",
                  hit_a, conf_a, cnt_a, mask_a);
      end
      checks++;
      if (di_b !== 8'hA5 || src_b !== 4'd2) begin
         errors++;
         $display("FAIL default_ch got=%h/%0d exp=a5/2", di_b, src_b);
      end
      checks++;
      if (di_8 !== 8'hFF || src_8 !== 4'd8) begin
         errors++;
         $display("FAIL reset_n8 got=%h/%0d exp=ff/8", di_8, src_8);
      end
   endtask

   task automatic test_conflict();
      sel  = 2'b11;
      ce   = 1'b1;
      rd_n = 1'b0;
      #1;
      checks++;
      if (di_a !== 8'h3C || src_a !== 4'd0) begin
         errors++;
         $display("FAIL conflict_di got=%h/%0d exp=3c/0", di_a, src_a);
      end
      tick();
      idle();
      checks++;
      if (conf_a !== 1'b1 || cnt_a !== 8'd1 || mask_a !== 2'b11) begin
         errors++;
         $display("FAIL conflict_flag got=%b/%0d/%b exp=1/1/11",
                  conf_a, cnt_a, mask_a);
      end
      checks++;
      if (hit_a !== 1'b0) begin
         errors++;
         $display("FAIL conflict_hit got=%b exp=0", hit_a);
      end
   endtask

   task automatic test_clear();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (conf_a !== 1'b0 || cnt_a !== 8'd0 || mask_a !== 2'b00) begin
         errors++;
         $display("FAIL clear got=%b/%0d/%b exp=0/0/00",
                  conf_a, cnt_a, mask_a);
      end
   endtask

   task automatic test_open_bus();
      sel    = 2'b00;
      wr_n   = 1'b0;
      cpu_do = 8'h5A;
      ce     = 1'b1;
      tick();
      idle();
      checks++;
      if (di_a !== 8'h5A || src_a !== 4'd2) begin
         errors++;
         $display("FAIL ob_write got=%h/%0d exp=5a/2", di_a, src_a);
      end
      ce   = 1'b1;
      rd_n = 1'b0;
      tick();
      idle();
      checks++;
      if (hit_a !== 1'b1 || di_a !== 8'h5A) begin
         errors++;
         $display("FAIL ob_hit got=%b/%h exp=1/5a", hit_a, di_a);
      end
      checks++;
      if (hit_b !== 1'b0) begin
         errors++;
         $display("FAIL ob_hit_b got=%b exp=0", hit_b);
      end
      tick();
      checks++;
      if (hit_a !== 1'b0) begin
         errors++;
         $display("FAIL ob_hit_pulse got=%b exp=0", hit_a);
      end
      wr_n   = 1'b0;
      rd_n   = 1'b0;
      cpu_do = 8'h11;
      tick();
      idle();
      checks++;
      if (di_a !== 8'h5A || hit_a !== 1'b0) begin
         errors++;
         $display("FAIL ob_no_ce got=%h/%b exp=5a/0", di_a, hit_a);
      end
      ce     = 1'b1;
      wr_n   = 1'b0;
      rd_n   = 1'b0;
      cpu_do = 8'hC3;
      tick();
      idle();
      checks++;
      if (di_a !== 8'hC3) begin
         errors++;
         $display("FAIL ob_both got=%h exp=c3", di_a);
      end
   endtask

   task automatic test_mask_en();
      sel      = 2'b01;
      en       = 2'b10;
      ch_do    = {8'h77, 8'h3C};
      ce       = 1'b1;
      rd_n     = 1'b0;
      #1;
      checks++;
      if (di_a !== 8'hC3 || src_a !== 4'd2) begin
         errors++;
         $display("FAIL mask_en_di got=%h/%0d exp=c3/2", di_a, src_a);
      end
      tick();
      idle();
      checks++;
      if (conf_a !== 1'b0 || hit_a !== 1'b1) begin
         errors++;
         $display("FAIL mask_en_state got=%b/%b exp=0/1", conf_a, hit_a);
      end
      sel  = 2'b10;
      en   = 2'b11;
      ce   = 1'b1;
      rd_n = 1'b0;
      #1;
      checks++;
      if (di_a !== 8'h77 || src_a !== 4'd1) begin
         errors++;
         $display("FAIL single_sel got=%h/%0d exp=77/1", di_a, src_a);
      end
      tick();
      idle();
      sel = 2'b00;
      #1;
      checks++;
      if (di_a !== 8'h77 || conf_a !== 1'b0 || hit_a !== 1'b0) begin
         errors++;
         $display("FAIL single_latch got=%h/%b/%b exp=77/0/0",
                  di_a, conf_a, hit_a);
      end
      sel   = 2'b11;
      wr_n  = 1'b0;
      ce    = 1'b1;
      tick();
      idle();
      checks++;
      if (conf_a !== 1'b0 || cnt_a !== 8'd0) begin
         errors++;
         $display("FAIL write_multi got=%b/%0d exp=0/0", conf_a, cnt_a);
      end
   endtask

   task automatic test_saturate();
      sel  = 2'b11;
      en   = 2'b11;
      ce   = 1'b1;
      rd_n = 1'b0;
      for (int i = 0; i < 300; i++) tick();
      checks++;
      if (cnt_a !== 8'd255 || conf_a !== 1'b1 || mask_a !== 2'b11) begin
         errors++;
         $display("FAIL saturate got=%0d/%b/%b exp=255/1/11",
                  cnt_a, conf_a, mask_a);
      end
      clr = 1'b1;
      tick();
      idle();
      checks++;
      if (cnt_a !== 8'd1 || conf_a !== 1'b1 || mask_a !== 2'b11) begin
         errors++;
         $display("FAIL clr_with_evt got=%0d/%b/%b exp=1/1/11",
                  cnt_a, conf_a, mask_a);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_nch8();
      sel8 = 8'b1010_0000;
      #1;
      checks++;
      if (src_8 !== 4'd5 || di_8 !== 8'h66) begin
         errors++;
         $display("FAIL n8_src got=%0d/%h exp=5/66", src_8, di_8);
      end
      sel  = 2'b00;
      ce   = 1'b1;
      rd_n = 1'b0;
      tick();
      sel8 = 8'h0C;
      tick();
      idle();
      checks++;
      if (mask_8 !== 8'hA0 || cnt_8 !== 8'd2 || conf_8 !== 1'b1) begin
         errors++;
         $display("FAIL n8_mask got=%h/%0d/%b exp=a0/2/1",
                  mask_8, cnt_8, conf_8);
      end
      checks++;
      if (src_8 !== 4'd2 || di_8 !== 8'h33) begin
         errors++;
         $display("FAIL n8_src2 got=%0d/%h exp=2/33", src_8, di_8);
      end
      sel8 = 8'h00;
   endtask

   task automatic test_reset_mid();
      sel  = 2'b11;
      ce   = 1'b1;
      rd_n = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sel   = 2'b00;
      idle();
      #1;
      checks++;
      if (conf_a !== 1'b0 || cnt_a !== 8'd0 || di_a !== 8'hFF) begin
         errors++;
         $display("FAIL reset_mid got=%b/%0d/%h exp=0/0/ff",
                  conf_a, cnt_a, di_a);
      end
      sel  = 2'b11;
      ce   = 1'b1;
      rd_n = 1'b0;
      tick();
      idle();
      checks++;
      if (cnt_a !== 8'd1 || conf_a !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_evt got=%0d/%b exp=1/1", cnt_a, conf_a);
      end
   endtask

   initial begin
      test_reset();
      test_conflict();
      test_clear();
      test_open_bus();
      test_mask_en();
      test_saturate();
      test_nch8();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 SHALL provide parameter NCH, default 2, meaning number of read-data sources (legal 1..8).
REQ-002 SHALL provide parameter OPEN_BUS, default 1, meaning 1 returns latched bus value when no source is selected, 0 returns the DEFAULT_CH source.
REQ-003 SHALL provide parameter DEFAULT_CH, default 0, meaning the fallback source index used when OPEN_BUS=0.
REQ-004 SHALL provide parameter OPEN_BUS_INIT, default 8'hFF, meaning the reset value of the open-bus latch.
REQ-005 MCLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RESET  in  1  reset; one clock, reset synchronous and active-high.
REQ-007 SYSCLKF_CE  in  1  end-of-CPU-cycle strobe, one MCLK wide.
REQ-008 CPURD_N, CPUWR_N  in  1 each  CPU read/write strobes, active low.
REQ-009 CPU_DO  in  8  CPU write data.
REQ-010 CH_SEL  in  NCH  per-source select; bit i high claims the bus.
REQ-011 CH_DO  in  NCH*8  source read data; source i on bits [8i+7:8i].
REQ-012 CH_EN  in  NCH  per-source enable mask.
REQ-013 CONFLICT_CLR  in  1  clears conflict status.
REQ-014 DI  out  8  read data to CPU.
REQ-015 DI_SRC  out  4  index of source driving DI; value NCH means open-bus/default.
REQ-016 OPEN_BUS_HIT  out  1  one-MCLK pulse per unclaimed read cycle.
REQ-017 CONFLICT  out  1  sticky multi-select flag.
REQ-018 CONFLICT_CNT  out  8  saturating conflict count.
REQ-019 CONFLICT_MASK  out  NCH  effective selects of first conflict since clear.

Function
REQ-020 Effective select eff SHALL equal CH_SEL AND CH_EN.
REQ-021 Winner SHALL be lowest set index of eff (source 0 highest priority).
REQ-022 DI SHALL be combinational, zero latency: CH_DO[winner] if eff!=0; else ob_q if OPEN_BUS=1; else CH_DO[DEFAULT_CH].
REQ-023 DI_SRC SHALL be combinational: winner index, or NCH when eff==0.
REQ-024 ob_q SHALL update only on MCLK edges with SYSCLKF_CE=1: CPUWR_N=0 -> CPU_DO; else CPURD_N=0 -> DI; else hold.
REQ-025 Both strobes low at SYSCLKF_CE SHALL be treated as write (CPU_DO captured).
REQ-026 ob_q SHALL NOT change when SYSCLKF_CE=0, regardless of strobes or selects.
REQ-027 OPEN_BUS_HIT SHALL be high exactly the MCLK cycle after an edge with SYSCLKF_CE=1, CPURD_N=0, eff==0, OPEN_BUS=1; else low.
REQ-028 Conflict event: edge with SYSCLKF_CE=1, CPURD_N=0, popcount(eff)>=2.
REQ-029 On conflict event: CONFLICT<=1; CONFLICT_CNT<=min(CNT+1,255); CONFLICT_MASK<=eff only if CONFLICT was 0.
REQ-030 CONFLICT_CNT SHALL saturate at 255, never wrap.
REQ-031 CONFLICT_CLR without event SHALL clear CONFLICT, CNT, MASK next edge.
REQ-032 CONFLICT_CLR with simultaneous event SHALL yield CONFLICT=1, CNT=1, MASK=eff.
REQ-033 Writes with multiple selects SHALL NOT count as conflicts.
REQ-034 NCH=1 SHALL never raise CONFLICT.

Reset
REQ-035 On RESET=1 at edge: ob_q=OPEN_BUS_INIT, OPEN_BUS_HIT=0, CONFLICT=0, CONFLICT_CNT=0, CONFLICT_MASK=0; RESET overrides all other updates same edge.
REQ-036 DI/DI_SRC SHALL remain combinational during reset (DI=OPEN_BUS_INIT if eff==0, OPEN_BUS=1).
REQ-037 Reset mid-conflict SHALL discard pending event; first post-reset event yields CNT=1.

Verification
REQ-038 NCH=2, CH_SEL=2'b11, CH_EN=2'b11, CH_DO={8'hA5,8'h3C}, read -> DI=3C, DI_SRC=0, CONFLICT=1, CNT=1, MASK=2'b11.
REQ-039 Write CPU_DO=8'h5A with SYSCLKF_CE, then unclaimed read -> DI=5A, DI_SRC=2, OPEN_BUS_HIT pulse one MCLK.
REQ-040 After reset, unclaimed read, OPEN_BUS=1 -> DI=FF; OPEN_BUS=0, DEFAULT_CH=1 -> DI=CH_DO[1].
REQ-041 CH_SEL=2'b01, CH_EN=2'b10, CH_DO[1]=8'h77 -> DI=open-bus value, no conflict.
REQ-042 300 conflict reads -> CNT=255; CONFLICT_CLR with event same edge -> CNT=1.
REQ-043 NCH=8, CH_SEL=8'b1010_0000 -> DI_SRC=5, MASK=8'hA0 on read.
